gshare_bp: RTL and testbench
============================

# gshare_bp

Parametrised gshare branch predictor for the fetch stage: a 2^INDEX_BITS-entry table of 2-bit saturating counters indexed by PC XOR global history, with clocked training from EX/MEM resolution. It adds speculative global history with checkpoint/recovery on mispredict, unconditional-jump forcing, and a saturating mispredict counter. Prediction is combinational to IF; training and history updates are synchronous.

## Interface
- GHR_BITS, 8, global history length; 1 ≤ GHR_BITS ≤ INDEX_BITS
- INDEX_BITS, 8, table index width; table depth 2^INDEX_BITS
- CNT_BITS, 16, mispredict counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pred_valid  in  1  IF lookup request this cycle
- pred_pc  in  32  PC of fetched instruction
- pred_opcode  in  7  opcode of fetched instruction
- pred_taken  out  1  predicted taken (combinational)
- pred_ghr  out  GHR_BITS  history used for this lookup; carried down the pipe with the branch
- upd_valid  in  1  resolution from EX/MEM this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_ghr  in  GHR_BITS  pred_ghr snapshot carried with that instruction
- upd_is_cond  in  1  resolved instruction is a conditional branch (opcode 1100011)
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  prediction was wrong (direction or target)
- mispredict_cnt  out  CNT_BITS  saturating mispredict count

## Operation
- Index: idx = pred_pc[INDEX_BITS+1:2] XOR zero-extended GHR; update index uses upd_pc and upd_ghr the same way.
- pred_taken = pred_valid & (opcode 1101111 or 1100111 → 1; opcode 1100011 → counter[idx] ≥ 2'b10; otherwise 0). rst high → 0.
- Counter update on upd_valid & upd_is_cond: taken → +1 saturating at 11; not taken → −1 saturating at 00. Jumps and non-branches never train.
- Same-cycle lookup and update to the same index: lookup sees the pre-update value (no bypass).
- mispredict_cnt increments on upd_valid & upd_mispredict; saturates at all-ones.
- Reset values: every counter 2'b01 (weak not-taken), GHR 0, mispredict_cnt 0, pred_taken 0. Reset mid-operation discards all history and training immediately.

## Timing
- Lookup: zero-cycle, combinational from pred_* and current GHR/table.
- Update: counter, GHR and mispredict_cnt change on the clk edge in which upd_valid is sampled; visible to lookups in the next cycle.
- GHR priority per edge: recovery (upd_valid & upd_mispredict & upd_is_cond) > speculative shift > hold.
- Back-to-back updates to the same index in consecutive cycles each apply; no lost writes.

## Configuration
- GSHARE_SPEC_GHR_EN defined: on pred_valid with opcode 1100011, GHR ← {GHR[GHR_BITS-2:0], pred_taken} at the edge. On recovery, GHR ← {upd_ghr[GHR_BITS-2:0], upd_taken}, overriding any same-cycle speculative shift.
- Undefined: GHR shifts only on upd_valid & upd_is_cond, GHR ← {GHR[GHR_BITS-2:0], upd_taken}; pred_ghr still reports the current GHR; upd_ghr is used only for the update index.

## Structure
- Package gshare_pkg: opcode constants (BRANCH 1100011, JAL 1101111, JALR 1100111), counter encodings (SNT 00, WNT 01, WT 10, ST 11), counter reset value.
- Sub-module gshare_bht: counter array with one combinational read port, one synchronous saturating read-modify-write port, and async reset to WNT.

## Test plan
- Reset, then lookup pred_pc=0x40, opcode 1100011 → pred_taken=0, pred_ghr=0, mispredict_cnt=0.
- Two updates upd_pc=0x40, upd_ghr=0, taken → counter[0x10]=11; lookup with GHR=0 → pred_taken=1; third taken update stays at 11.
- Lookups with opcode 1101111 and 1100111 → pred_taken=1 regardless of counter; GHR unchanged; upd_is_cond=0 update leaves the table unchanged.
- SPEC_EN: predict taken with GHR=0x00 → GHR=0x01; same cycle as a new lookup, recovery with upd_ghr=0x00, upd_taken=0 → GHR=0x00 (recovery wins).
- Same-cycle lookup and update to idx 0x10: pred_taken reflects old value; next cycle reflects new value.
- With CNT_BITS=2, four mispredicts → mispredict_cnt=3; assert rst mid-run → all outputs and counters return to reset values asynchronously.

Source files
------------

// File: rtl/gshare_pkg.sv
// gshare_pkg: shared constants and helpers for the gshare branch predictor.
//   - RISC-V control-flow opcodes (conditional branch, JAL, JALR)
//   - 2-bit saturating counter encodings and their reset value
//   - counter next-state and direction helpers
package gshare_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Saturating step: taken moves toward ST, not taken toward SNT.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

  // Upper half of the counter range predicts taken.
  function automatic logic ctr_is_taken(input ctr_t cur);
    return (cur == WT) || (cur == ST);
  endfunction

endpackage

// File: rtl/gshare_bht.sv
// gshare_bht: table of 2^INDEX_BITS two-bit saturating counters.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_ctr   combinational read port
//   wr_en / wr_idx /  synchronous read-modify-write port; wr_taken selects
//   wr_taken          increment or decrement of the addressed counter
// The write port reads the stored value directly every cycle, so updates to
// the same entry in consecutive cycles accumulate. The read port returns the
// pre-edge value even when the same entry is written in that cycle.
module gshare_bht
  import gshare_pkg::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output ctr_t                  rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;

  ctr_t ctr_mem_r [DEPTH];

  assign rd_ctr = ctr_mem_r[rd_idx];

  // Counter storage: async clear to weak not-taken, saturating update on write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_mem_r[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr_mem_r[wr_idx] <= ctr_next(ctr_mem_r[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// gshare_bp: gshare direction predictor for the fetch stage.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pred_valid/pc/opcode  IF lookup request
//   pred_taken            combinational prediction (jumps always taken)
//   pred_ghr              history used for this lookup, carried with the branch
//   upd_valid/pc/ghr/     EX/MEM resolution: trains the counter addressed by
//   is_cond/taken/        upd_pc ^ upd_ghr for conditional branches
//   mispredict
//   mispredict_cnt        saturating count of resolved mispredicts
// Build option GSHARE_SPEC_GHR_EN: history is shifted speculatively with each
// predicted conditional branch and restored from upd_ghr on a conditional
// mispredict. Without it, history shifts only with resolved conditional
// outcomes.
module gshare_bp
  import gshare_pkg::*;
#(
  parameter int GHR_BITS   = 8,
  parameter int INDEX_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  input  logic [6:0]          pred_opcode,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [CNT_BITS-1:0] mispredict_cnt
);

  logic [GHR_BITS-1:0]   ghr_r;
  logic [GHR_BITS-1:0]   ghr_next_s;
  logic [CNT_BITS-1:0]   cnt_r;
  logic [INDEX_BITS-1:0] rd_idx_s;
  logic [INDEX_BITS-1:0] wr_idx_s;
  ctr_t                  rd_ctr_s;
  logic                  unused_s;

  function automatic logic [INDEX_BITS-1:0] bht_index(input logic [31:0]         pc,
                                                      input logic [GHR_BITS-1:0] ghr);
    return pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  endfunction

  // Shift a new outcome into the LSB; the cast drops the oldest bit.
  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] ghr,
                                                    input logic                bit_in);
    return GHR_BITS'({ghr, bit_in});
  endfunction

  // PC bits outside the index field carry no information for this table.
  assign unused_s = ^{pred_pc, upd_pc};

  assign rd_idx_s = bht_index(pred_pc, ghr_r);
  assign wr_idx_s = bht_index(upd_pc, upd_ghr);

  gshare_bht #(
    .INDEX_BITS (INDEX_BITS)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx_s),
    .rd_ctr   (rd_ctr_s),
    .wr_en    (upd_valid && upd_is_cond),
    .wr_idx   (wr_idx_s),
    .wr_taken (upd_taken)
  );

  // Direction lookup: jumps forced taken, conditional branches use the counter.
  always_comb begin
    pred_taken = 1'b0;
    if (rst || !pred_valid) begin
      pred_taken = 1'b0;
    end else begin
      case (pred_opcode)
        OPC_JAL, OPC_JALR: pred_taken = 1'b1;
        OPC_BRANCH:        pred_taken = ctr_is_taken(rd_ctr_s);
        default:           pred_taken = 1'b0;
      endcase
    end
  end

`ifdef GSHARE_SPEC_GHR_EN
  // Speculative history: recovery from the resolved snapshot beats the shift.
  always_comb begin
    ghr_next_s = ghr_r;
    if (upd_valid && upd_mispredict && upd_is_cond) begin
      ghr_next_s = ghr_shift(upd_ghr, upd_taken);
    end else if (pred_valid && (pred_opcode == OPC_BRANCH)) begin
      ghr_next_s = ghr_shift(ghr_r, pred_taken);
    end else begin
      ghr_next_s = ghr_r;
    end
  end
`else
  // Non-speculative history: shift in resolved conditional outcomes only.
  always_comb begin
    ghr_next_s = ghr_r;
    if (upd_valid && upd_is_cond) begin
      ghr_next_s = ghr_shift(ghr_r, upd_taken);
    end else begin
      ghr_next_s = ghr_r;
    end
  end
`endif

  // Global history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else begin
      ghr_r <= ghr_next_s;
    end
  end

  // Mispredict counter, holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_BITS{1'b0}};
    end else if (upd_valid && upd_mispredict && (cnt_r != {CNT_BITS{1'b1}})) begin
      cnt_r <= cnt_r + CNT_BITS'(1);
    end
  end

  assign pred_ghr       = ghr_r;
  assign mispredict_cnt = cnt_r;

endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: directed self-checking bench for gshare_bp (8-bit history and
// index, 2-bit mispredict counter so saturation is reached quickly). Expected
// history values follow whichever GHR mode the build selects.
module tb_gshare_bp;
  import gshare_pkg::*;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [6:0]  pred_opcode;
  logic        pred_taken;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_is_cond;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [1:0]  mispredict_cnt;

  int         n_assert;
  int         n_fail;
  logic [7:0] ghr_exp;

  gshare_bp #(
    .GHR_BITS   (8),
    .INDEX_BITS (8),
    .CNT_BITS   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_opcode    (pred_opcode),
    .pred_taken     (pred_taken),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_is_cond    (upd_is_cond),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .mispredict_cnt (mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    pred_valid     = 1'b0;
    pred_pc        = 32'd0;
    pred_opcode    = 7'd0;
    upd_valid      = 1'b0;
    upd_pc         = 32'd0;
    upd_ghr        = 8'd0;
    upd_is_cond    = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [6:0] opc);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_opcode = opc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic cond,
                     input logic taken, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_ghr        = g;
    upd_is_cond    = cond;
    upd_taken      = taken;
    upd_mispredict = misp;
  endtask

  // PC whose lookup lands on table entry idx under history g.
  function automatic logic [31:0] pc_for(input logic [7:0] idx, input logic [7:0] g);
    return {22'd0, idx ^ g, 2'b00};
  endfunction

  function automatic logic [7:0] sh(input logic [7:0] g, input logic b);
    return {g[6:0], b};
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    ghr_exp  = 8'h00;
    idle();
    rst = 1'b1;

    // Reset state: even a jump lookup is suppressed while reset is high.
    lookup(32'h40, OPC_JAL);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    check("rst_cnt", 32'(mispredict_cnt), 32'd0);
    tick();
    rst = 1'b0;
    idle();

    // Cold lookup of 0x40: entry 0x10 is weak not-taken.
    lookup(32'h40, OPC_BRANCH);
    check("cold_pred_taken", 32'(pred_taken), 32'd0);
    check("cold_pred_ghr", 32'(pred_ghr), 32'd0);
    check("cold_cnt", 32'(mispredict_cnt), 32'd0);
    pred_valid = 1'b0;

    // Two back-to-back taken updates to entry 0x10: WNT -> WT -> ST.
    upd(32'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    upd(32'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
`ifndef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(sh(ghr_exp, 1'b1), 1'b1);
`endif
    check("train_ghr", 32'(pred_ghr), 32'(ghr_exp));
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("trained_taken", 32'(pred_taken), 32'd1);
    pred_valid = 1'b0;

    // Third taken holds ST; then two not-taken: ST -> WT (taken) -> WNT.
    upd(32'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    upd(32'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
`ifndef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(sh(ghr_exp, 1'b1), 1'b0);
`endif
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("sat_hi_then_dec", 32'(pred_taken), 32'd1);
    pred_valid = 1'b0;
    upd(32'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
`ifndef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(ghr_exp, 1'b0);
`endif
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("dec_to_wnt", 32'(pred_taken), 32'd0);
    check("dec_ghr", 32'(pred_ghr), 32'(ghr_exp));
    pred_valid = 1'b0;

    // Jumps forced taken on a not-taken entry; other opcodes never taken.
    lookup(pc_for(8'h10, ghr_exp), OPC_JAL);
    check("jal_taken", 32'(pred_taken), 32'd1);
    lookup(pc_for(8'h10, ghr_exp), OPC_JALR);
    check("jalr_taken", 32'(pred_taken), 32'd1);
    lookup(pc_for(8'h10, ghr_exp), 7'b0110011);
    check("alu_not_taken", 32'(pred_taken), 32'd0);
    lookup(pc_for(8'h10, ghr_exp), OPC_JAL);
    tick();
    pred_valid = 1'b0;
    check("jal_ghr_hold", 32'(pred_ghr), 32'(ghr_exp));

    // Non-conditional resolutions never train or shift history.
    upd(32'h40, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    idle();
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("noncond_no_train", 32'(pred_taken), 32'd0);
    check("noncond_ghr", 32'(pred_ghr), 32'(ghr_exp));
    pred_valid = 1'b0;

    // Same-cycle lookup and update of entry 0x10 (WNT -> WT): no bypass.
    upd(32'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("same_cycle_old", 32'(pred_taken), 32'd0);
    tick();
    idle();
`ifdef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(ghr_exp, 1'b0);
`else
    ghr_exp = sh(ghr_exp, 1'b1);
`endif
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("next_cycle_new", 32'(pred_taken), 32'd1);

    // Predicted-taken branch held through the edge.
    tick();
`ifdef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(ghr_exp, 1'b1);
`endif
    check("spec_shift_ghr", 32'(pred_ghr), 32'(ghr_exp));

    // Conditional mispredict with a new lookup in the same cycle.
    upd(32'h80, 8'h00, 1'b1, 1'b0, 1'b1);
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    tick();
    idle();
`ifdef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(8'h00, 1'b0);
`else
    ghr_exp = sh(ghr_exp, 1'b0);
`endif
    check("recover_ghr", 32'(pred_ghr), 32'(ghr_exp));
    check("cnt_one", 32'(mispredict_cnt), 32'd1);

    // Mispredict counter: counts only with upd_valid, saturates at 3.
    upd(32'h100, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check("cnt_two", 32'(mispredict_cnt), 32'd2);
    upd_mispredict = 1'b1;
    tick();
    check("cnt_no_valid", 32'(mispredict_cnt), 32'd2);
    upd(32'h100, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check("cnt_three", 32'(mispredict_cnt), 32'd3);
    tick();
    idle();
    check("cnt_saturate", 32'(mispredict_cnt), 32'd3);
    check("noncond_misp_ghr", 32'(pred_ghr), 32'(ghr_exp));

    // Build up a nonzero state, then reset mid-cycle.
    lookup(pc_for(8'h10, ghr_exp), OPC_BRANCH);
    check("pre_rst_taken", 32'(pred_taken), 32'd1);
    tick();
`ifdef GSHARE_SPEC_GHR_EN
    ghr_exp = sh(ghr_exp, 1'b1);
`endif
    check("pre_rst_ghr", 32'(pred_ghr), 32'(ghr_exp));
    lookup(pc_for(8'h10, ghr_exp), OPC_JAL);
    rst = 1'b1;
    #1;
    check("midrst_pred_taken", 32'(pred_taken), 32'd0);
    check("midrst_pred_ghr", 32'(pred_ghr), 32'd0);
    check("midrst_cnt", 32'(mispredict_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    ghr_exp = 8'h00;
    lookup(32'h40, OPC_BRANCH);
    check("post_rst_table", 32'(pred_taken), 32'd0);
    check("post_rst_ghr", 32'(pred_ghr), 32'd0);
    pred_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
